// File: rtl/dpsram_be_if.sv
// Port bundle for the dual-port byte-enable SRAM: write port, read request, read response.
// The memory side takes the slave modport, the requester the master modport.
interface dpsram_be_if #(
  parameter int BW_DATA = 32,
  parameter int BW_ADDR = 5
) ();
  localparam int BW_BE = BW_DATA / 8;

  logic               i_wr_cen;
  logic [BW_ADDR-1:0] i_wr_addr;
  logic [BW_DATA-1:0] i_wr_data;
  logic [BW_BE-1:0]   i_wr_be;
  logic               i_rd_cen;
  logic [BW_ADDR-1:0] i_rd_addr;
  logic [BW_DATA-1:0] o_rd_data;
  logic               o_rd_valid;
  logic               o_rdw_hit;

  modport master (
    output i_wr_cen, i_wr_addr, i_wr_data, i_wr_be, i_rd_cen, i_rd_addr,
    input  o_rd_data, o_rd_valid, o_rdw_hit
  );

  modport slave (
    input  i_wr_cen, i_wr_addr, i_wr_data, i_wr_be, i_rd_cen, i_rd_addr,
    output o_rd_data, o_rd_valid, o_rdw_hit
  );
endinterface

// File: rtl/dpsram_be.sv
// Dual-port synchronous SRAM, one byte-enabled write port and one pipelined read port (1 or 2 cycles).
// Reads never stall; same-address read/write resolves old-word or merged-new-word per RDW_MODE.
module dpsram_be #(
  parameter int BW_DATA    = 32,
  parameter int BW_ADDR    = 5,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input logic       i_clk,
  input logic       i_rst,
  dpsram_be_if.slave bus
);
  localparam int BW_BE = BW_DATA / 8;
  localparam int DEPTH = 2 ** BW_ADDR;

  if (BW_DATA % 8 != 0) begin : g_bad_bw_data
    $error("dpsram_be: BW_DATA must be a multiple of 8");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_rd_latency
    $error("dpsram_be: RD_LATENCY must be 1 or 2");
  end
  if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_bad_rdw_mode
    $error("dpsram_be: RDW_MODE must be 0 or 1");
  end
  if ($bits(bus.i_wr_data) != BW_DATA || $bits(bus.i_wr_addr) != BW_ADDR) begin : g_bad_if
    $error("dpsram_be: interface widths do not match module parameters");
  end

  logic [BW_DATA-1:0] mem_q [DEPTH];

  logic               wr_en;
  logic               rd_en;
  logic               rdw_hit;
  logic [BW_DATA-1:0] wr_word_d;
  logic [BW_DATA-1:0] rd_word;

  logic               s1_vld_d, s1_vld_q;
  logic               s1_hit_d, s1_hit_q;
  logic [BW_DATA-1:0] s1_dat_d, s1_dat_q;
  logic               s2_vld_d, s2_vld_q;
  logic               s2_hit_d, s2_hit_q;
  logic [BW_DATA-1:0] s2_dat_d, s2_dat_q;

  always_comb begin
    wr_en   = ~i_rst & bus.i_wr_cen;
    rd_en   = ~i_rst & bus.i_rd_cen;
    rdw_hit = rd_en & wr_en & (bus.i_rd_addr == bus.i_wr_addr);

    // Merged word doubles as the write-first read result on a collision.
    wr_word_d = mem_q[bus.i_wr_addr];
    for (int b = 0; b < BW_BE; b++) begin
      if (bus.i_wr_be[b]) begin
        wr_word_d[8*b +: 8] = bus.i_wr_data[8*b +: 8];
      end
    end
    rd_word = (RDW_MODE == 1 && rdw_hit) ? wr_word_d : mem_q[bus.i_rd_addr];

    s1_vld_d = rd_en;
    s1_hit_d = rdw_hit;
    s1_dat_d = rd_en ? rd_word : s1_dat_q;
    s2_vld_d = s1_vld_q;
    s2_hit_d = s1_hit_q;
    s2_dat_d = s1_vld_q ? s1_dat_q : s2_dat_q;
  end

  // Array contents survive reset by design.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_q[bus.i_wr_addr] <= wr_word_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_vld_q <= 1'b0;
      s1_hit_q <= 1'b0;
      s1_dat_q <= '0;
      s2_vld_q <= 1'b0;
      s2_hit_q <= 1'b0;
      s2_dat_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_hit_q <= s1_hit_d;
      s1_dat_q <= s1_dat_d;
      s2_vld_q <= s2_vld_d;
      s2_hit_q <= s2_hit_d;
      s2_dat_q <= s2_dat_d;
    end
  end

  assign bus.o_rd_data  = (RD_LATENCY == 1) ? s1_dat_q : s2_dat_q;
  assign bus.o_rd_valid = (RD_LATENCY == 1) ? s1_vld_q : s2_vld_q;
  assign bus.o_rdw_hit  = (RD_LATENCY == 1) ? s1_hit_q : s2_hit_q;
endmodule

// File: tb/tb_dpsram_be.sv
// Drives a read-first/latency-1 instance and a write-first/latency-2 instance with identical stimulus.
// Expected words are supplied per request and delayed to each instance's output cycle.
module tb_dpsram_be;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dpsram_be_if #(.BW_DATA(32), .BW_ADDR(5)) if_a ();
  dpsram_be_if #(.BW_DATA(32), .BW_ADDR(5)) if_b ();

  dpsram_be #(.BW_DATA(32), .BW_ADDR(5), .RD_LATENCY(1), .RDW_MODE(0)) u_a (
    .i_clk(clk), .i_rst(rst), .bus(if_a.slave));
  dpsram_be #(.BW_DATA(32), .BW_ADDR(5), .RD_LATENCY(2), .RDW_MODE(1)) u_b (
    .i_clk(clk), .i_rst(rst), .bus(if_b.slave));

  int n_cmp = 0;
  int n_err = 0;
  int n_req = 0;
  int n_va  = 0;
  int n_vb  = 0;
  bit chk_en = 1'b0;

  logic        d_rc = 1'b0;
  logic [31:0] d_ea = '0;
  logic [31:0] d_eb = '0;
  logic        d_eh = 1'b0;
  logic [31:0] mdl [32];

  logic        pa_vld, pa_hit, b1_vld, b1_hit, pb_vld, pb_hit;
  logic [31:0] pa_dat, b1_dat, pb_dat;

  // Expected responses: one cycle late for instance A, two for B; reset wipes anything in flight.
  always @(posedge clk) begin
    if (rst) begin
      pa_vld <= 1'b0; pa_hit <= 1'b0; pa_dat <= '0;
      b1_vld <= 1'b0; b1_hit <= 1'b0; b1_dat <= '0;
      pb_vld <= 1'b0; pb_hit <= 1'b0; pb_dat <= '0;
    end else begin
      pa_vld <= d_rc;
      pa_hit <= d_rc & d_eh;
      if (d_rc) pa_dat <= d_ea;
      b1_vld <= d_rc;
      b1_hit <= d_rc & d_eh;
      if (d_rc) b1_dat <= d_eb;
      pb_vld <= b1_vld;
      pb_hit <= b1_hit;
      if (b1_vld) pb_dat <= b1_dat;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_valid", {31'b0, if_a.o_rd_valid}, {31'b0, pa_vld});
      chk("a_hit",   {31'b0, if_a.o_rdw_hit},  {31'b0, pa_hit});
      chk("a_data",  if_a.o_rd_data, pa_dat);
      chk("b_valid", {31'b0, if_b.o_rd_valid}, {31'b0, pb_vld});
      chk("b_hit",   {31'b0, if_b.o_rdw_hit},  {31'b0, pb_hit});
      chk("b_data",  if_b.o_rd_data, pb_dat);
      if (if_a.o_rd_valid === 1'b1) n_va++;
      if (if_b.o_rd_valid === 1'b1) n_vb++;
    end
  end

  task automatic drive(input logic wc, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic rc, input logic [4:0] ra,
                       input logic [31:0] ea, input logic [31:0] eb, input logic eh);
    if_a.i_wr_cen = wc; if_a.i_wr_addr = wa; if_a.i_wr_data = wd; if_a.i_wr_be = be;
    if_a.i_rd_cen = rc; if_a.i_rd_addr = ra;
    if_b.i_wr_cen = wc; if_b.i_wr_addr = wa; if_b.i_wr_data = wd; if_b.i_wr_be = be;
    if_b.i_rd_cen = rc; if_b.i_rd_addr = ra;
    d_rc = rc; d_ea = ea; d_eb = eb; d_eh = eh;
    if (rc && !rst) n_req++;
    if (wc && !rst) begin
      for (int b = 0; b < 4; b++) if (be[b]) mdl[wa][8*b +: 8] = wd[8*b +: 8];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [4:0] wa, input logic [31:0] wd, input logic [3:0] be);
    drive(1'b1, wa, wd, be, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic rd(input logic [4:0] ra, input logic [31:0] ea, input logic [31:0] eb);
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, ra, ea, eb, 1'b0);
  endtask

  initial begin
    logic [4:0]  ra, wa;
    logic [31:0] wd, old, merged;
    logic [3:0]  be;
    logic        rc, wc, hit;

    // Reset with registers unknown, then start checking.
    rst = 1'b1;
    idle(2);
    chk_en = 1'b1;
    rst = 1'b0;
    wr(5'd9, 32'hCAFEBABE, 4'hF);

    // Reset held 3 cycles with reads requested: nothing may come out.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd9, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    rd(5'd9, 32'hCAFEBABE, 32'hCAFEBABE);
    idle(2);

    // Full sweep, then 32 back-to-back reads.
    for (int a = 0; a < 32; a++) wr(5'(a), 32'(a) * 32'h01010101, 4'hF);
    for (int a = 0; a < 32; a++) rd(5'(a), 32'(a) * 32'h01010101, 32'(a) * 32'h01010101);
    idle(3);

    // Byte enables.
    wr(5'd7, 32'hAABBCCDD, 4'hF);
    wr(5'd7, 32'h11223344, 4'h5);
    rd(5'd7, 32'hAA22CC44, 32'hAA22CC44);
    idle(2);

    // Collisions: partial-lane write, then empty-lane write, then plain reads.
    wr(5'd3, 32'h12345678, 4'hF);
    idle(1);
    drive(1'b1, 5'd3, 32'hFFFFFFFF, 4'h3, 1'b1, 5'd3, 32'h12345678, 32'h1234FFFF, 1'b1);
    rd(5'd3, 32'h1234FFFF, 32'h1234FFFF);
    drive(1'b1, 5'd3, 32'h00000000, 4'h0, 1'b1, 5'd3, 32'h1234FFFF, 32'h1234FFFF, 1'b1);
    rd(5'd3, 32'h1234FFFF, 32'h1234FFFF);
    idle(2);

    // Write then read on the next cycle sees the new word in both modes.
    wr(5'd12, 32'hDEADBEEF, 4'hF);
    rd(5'd12, 32'hDEADBEEF, 32'hDEADBEEF);
    idle(3);

    // Reset one cycle after a read: the 2-stage instance must drop it.
    rd(5'd5, 32'h05050505, 32'h05050505);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    rd(5'd6, 32'h06060606, 32'h06060606);
    idle(3);

    // Random interleaved traffic on a narrow address range to provoke collisions.
    n_req = 0; n_va = 0; n_vb = 0;
    for (int i = 0; i < 10000; i++) begin
      wc = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 7));
      ra = 5'($urandom_range(0, 7));
      wd = $urandom;
      be = 4'($urandom);
      hit = wc & rc & (wa == ra);
      old = mdl[ra];
      merged = old;
      for (int b = 0; b < 4; b++) if (be[b]) merged[8*b +: 8] = wd[8*b +: 8];
      drive(wc, wa, wd, be, rc, ra, old, hit ? merged : old, hit);
    end
    idle(3);
    chk("a_valid_count", 32'(n_va), 32'(n_req));
    chk("b_valid_count", 32'(n_vb), 32'(n_req));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dpsram_be.md
Name: dpsram_be

Overview:
Simple dual-port synchronous SRAM model: one write port and one independent read port, sharing a single clock.
- Write port supports per-byte write enables.
- Read port has a parametrised pipeline latency and a read-valid strobe.
- Same-address read/write collisions resolve under a selectable policy.
Used as the generic buffer memory under FIFOs and line buffers, replacing single-port instances wherever concurrent read/write is needed.

Parameters:
BW_DATA, 32, data word width in bits; must be a multiple of 8 (elaboration error otherwise).
BW_ADDR, 5, address width; depth = 2**BW_ADDR words.
RD_LATENCY, 1, read latency in cycles from the read-request edge to data; legal values 1 or 2 (elaboration error otherwise).
RDW_MODE, 0, same-address read-during-write policy: 0 = read-first (old word), 1 = write-first (merged new word).
BW_BE, BW_DATA/8, derived localparam: number of byte lanes.

Ports:
i_clk  input  1  clock; all logic on rising edge.
i_rst  input  1  reset, synchronous, active-high.
i_wr_cen  input  1  write port enable.
i_wr_addr  input  BW_ADDR  write address.
i_wr_data  input  BW_DATA  write data.
i_wr_be  input  BW_BE  byte enables; bit b controls bits [8b+7:8b].
i_rd_cen  input  1  read request.
i_rd_addr  input  BW_ADDR  read address.
o_rd_data  output  BW_DATA  read data, registered.
o_rd_valid  output  1  high for exactly the cycle(s) o_rd_data carries requested data.
o_rdw_hit  output  1  high together with o_rd_valid when that read collided with a same-address write.

Behaviour:
- Reset: while i_rst=1 at a rising edge: o_rd_data <= 0, o_rd_valid <= 0, o_rdw_hit <= 0, all internal read pipeline stages cleared (valid and data). Memory array is NOT cleared; contents are preserved across reset. Writes and reads presented in a reset cycle are ignored.
- Write: at a rising edge with i_rst=0 and i_wr_cen=1, for each b with i_wr_be[b]=1, mem[i_wr_addr][8b+7:8b] <= i_wr_data[8b+7:8b]. Lanes with be=0 are unchanged. i_wr_cen=1 with i_wr_be=0 leaves memory unchanged. i_wr_cen=0 ignores i_wr_be.
- Read: a request is i_rd_cen=1 at a rising edge with i_rst=0.
  - RD_LATENCY=1: data and o_rd_valid=1 appear after that same edge (one cycle).
  - RD_LATENCY=2: the word is captured into a stage register, then moves to o_rd_data one edge later.
  - Reads are fully pipelined: one request per cycle, in order, no stalls.
- Idle: cycles without a completing read drive o_rd_valid=0 and o_rdw_hit=0. o_rd_data holds its last value and never goes X or Z.
- Collision: i_rd_cen=1, i_wr_cen=1 and i_rd_addr==i_wr_addr at the same edge.
  - RDW_MODE=0: the read returns the pre-write word.
  - RDW_MODE=1: the read returns, per lane, i_wr_data where i_wr_be=1, else the old word.
  - In both modes the write still commits, and o_rdw_hit=1 with that read's data.
  - A collision with be=0 still sets o_rdw_hit, and the data equals the old word.
- Write-then-read on consecutive cycles to the same address returns the new data regardless of RDW_MODE.
- Reset mid-read (RD_LATENCY=2): if a request is in the stage register when i_rst rises, it is dropped and o_rd_valid stays 0. A request on the first edge after i_rst falls is serviced normally.
- Address wrap: all 2**BW_ADDR addresses are valid; there is no out-of-range case.

Test Plan:
1. Reset: hold i_rst=1 for 3 cycles with i_rd_cen=1 -> o_rd_data=0, o_rd_valid=0, o_rdw_hit=0 on every cycle; memory written before reset reads back unchanged afterwards.
2. Full sweep, RD_LATENCY=1 and 2: write mem[a]=a*0x01010101 for a=0..31 with be=0xF, then read 0..31 back-to-back -> 32 consecutive valid words, in order, first one arriving exactly RD_LATENCY cycles after the first request.
3. Byte enables: write 0xAABBCCDD to addr 7 with be=0xF, then 0x11223344 with be=0x5 -> read 7 returns 0xAA22CC44.
4. Collision: mem[3]=0x12345678; same edge write 0xFFFFFFFF be=0x3 plus read addr 3 -> RDW_MODE=0 returns 0x12345678, RDW_MODE=1 returns 0x1234FFFF, o_rdw_hit=1; a following read returns 0x1234FFFF with o_rdw_hit=0.
5. Reset mid-read (RD_LATENCY=2): issue read at cycle N, assert i_rst at N+1 -> no o_rd_valid pulse. A read issued the first cycle after reset releases gets valid data 2 cycles later.
6. Randomised interleaved read/write against a scoreboard model, 10k cycles, both RDW_MODE values -> zero mismatches; o_rd_valid count equals accepted request count.
